// File: rtl/command_parse_and_encapsulate_mcc.sv
// Register-mapped command parser for the per-channel cycle-control settings.
// Each channel has four words: operation base high/low, cycle length, and status.
// The 64-bit operation base is written through a shadow high word, so the
// active value only changes when the low word lands.
module command_parse_and_encapsulate_mcc #(
    parameter int          CH_NUM        = 4,
    parameter logic [31:0] DEF_CYCLE_LEN = 32'd100000,
    parameter logic [63:0] DEF_OPER_BASE = 64'd60000000000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr_cc,
    input  logic [31:0]            iv_wdata_cc,
    input  logic [18:0]            iv_addr_cc,
    input  logic                   i_addr_fixed_cc,
    input  logic                   i_rd_cc,
    output logic                   o_wr_cc,
    output logic [31:0]            ov_rdata_cc,
    output logic [18:0]            ov_raddr_cc,
    output logic                   o_addr_fixed_cc,
    output logic [CH_NUM*32-1:0]   ov_cycle_length,
    output logic [CH_NUM*64-1:0]   ov_oper_base,
    output logic [CH_NUM-1:0]      ov_cfg_update,
    output logic                   o_addr_err
);

    logic [31:0]       chan_idx;
    logic [1:0]        offset;
    logic              mapped;
    logic              wr_hit;
    logic              rd_hit;
    logic              err_hit;

    logic [31:0]       cycle_len_q   [CH_NUM];
    logic [31:0]       cycle_len_d   [CH_NUM];
    logic [63:0]       oper_base_q   [CH_NUM];
    logic [63:0]       oper_base_d   [CH_NUM];
    logic [31:0]       shadow_hi_q   [CH_NUM];
    logic [31:0]       shadow_hi_d   [CH_NUM];
    logic [CH_NUM-1:0] shadow_pend_q, shadow_pend_d;
    logic [CH_NUM-1:0] zlen_err_q,    zlen_err_d;
    logic [CH_NUM-1:0] cfg_update_q,  cfg_update_d;
    logic              addr_err_q,    addr_err_d;
    logic              rsp_valid_q,   rsp_valid_d;
    logic [31:0]       rsp_data_q,    rsp_data_d;
    logic [18:0]       rsp_addr_q,    rsp_addr_d;
    logic              rsp_fixed_q,   rsp_fixed_d;

    // Address decode; a simultaneous write wins and the read is dropped
    always_comb begin
        chan_idx = {15'd0, iv_addr_cc[18:2]};
        offset   = iv_addr_cc[1:0];
        mapped   = !i_addr_fixed_cc && (chan_idx < CH_NUM);
        wr_hit   = i_wr_cc && mapped;
        rd_hit   = i_rd_cc && !i_wr_cc && mapped;
        err_hit  = !i_addr_fixed_cc && !mapped && (i_wr_cc || i_rd_cc);
    end

    // Next-state for the register file, the read response and the pulses
    always_comb begin
        cycle_len_d   = cycle_len_q;
        oper_base_d   = oper_base_q;
        shadow_hi_d   = shadow_hi_q;
        shadow_pend_d = shadow_pend_q;
        zlen_err_d    = zlen_err_q;
        cfg_update_d  = '0;
        addr_err_d    = err_hit;
        rsp_valid_d   = rd_hit;
        rsp_data_d    = '0;
        rsp_addr_d    = rd_hit ? iv_addr_cc : 19'd0;
        rsp_fixed_d   = rd_hit ? i_addr_fixed_cc : 1'b0;
        for (int c = 0; c < CH_NUM; c++) begin
            if (chan_idx == c) begin
                if (rd_hit) begin
                    case (offset)
                        2'd0:    rsp_data_d = oper_base_q[c][63:32];
                        2'd1:    rsp_data_d = oper_base_q[c][31:0];
                        2'd2:    rsp_data_d = cycle_len_q[c];
                        default: rsp_data_d = {30'd0, zlen_err_q[c], shadow_pend_q[c]};
                    endcase
                end
                if (wr_hit) begin
                    case (offset)
                        2'd0: begin
                            shadow_hi_d[c]   = iv_wdata_cc;
                            shadow_pend_d[c] = 1'b1;
                        end
                        2'd1: begin
                            oper_base_d[c]   = {shadow_pend_q[c] ? shadow_hi_q[c] : oper_base_q[c][63:32],
                                                iv_wdata_cc};
                            shadow_pend_d[c] = 1'b0;
                            cfg_update_d[c]  = 1'b1;
                        end
                        2'd2: begin
                            if (iv_wdata_cc != 32'd0) begin
                                cycle_len_d[c]  = iv_wdata_cc;
                                cfg_update_d[c] = 1'b1;
                            end else begin
                                zlen_err_d[c]   = 1'b1;
                            end
                        end
                        default: begin
                            if (iv_wdata_cc[1]) begin
                                zlen_err_d[c] = 1'b0;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // State registers, defaults loaded asynchronously on reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int c = 0; c < CH_NUM; c++) begin
                cycle_len_q[c] <= DEF_CYCLE_LEN;
                oper_base_q[c] <= DEF_OPER_BASE;
                shadow_hi_q[c] <= 32'd0;
            end
            shadow_pend_q <= '0;
            zlen_err_q    <= '0;
            cfg_update_q  <= '0;
            addr_err_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 32'd0;
            rsp_addr_q    <= 19'd0;
            rsp_fixed_q   <= 1'b0;
        end else begin
            cycle_len_q   <= cycle_len_d;
            oper_base_q   <= oper_base_d;
            shadow_hi_q   <= shadow_hi_d;
            shadow_pend_q <= shadow_pend_d;
            zlen_err_q    <= zlen_err_d;
            cfg_update_q  <= cfg_update_d;
            addr_err_q    <= addr_err_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_addr_q    <= rsp_addr_d;
            rsp_fixed_q   <= rsp_fixed_d;
        end
    end

    // Flatten the active per-channel values onto the output buses
    always_comb begin
        ov_cycle_length = '0;
        ov_oper_base    = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            ov_cycle_length[c*32 +: 32] = cycle_len_q[c];
            ov_oper_base[c*64 +: 64]    = oper_base_q[c];
        end
    end

    assign o_wr_cc         = rsp_valid_q;
    assign ov_rdata_cc     = rsp_data_q;
    assign ov_raddr_cc     = rsp_addr_q;
    assign o_addr_fixed_cc = rsp_fixed_q;
    assign ov_cfg_update   = cfg_update_q;
    assign o_addr_err      = addr_err_q;

endmodule

// File: tb/tb_command_parse_and_encapsulate_mcc.sv
// Testbench for command_parse_and_encapsulate_mcc: directed commands against a
// small register model, with read responses checked through a scoreboard.
module tb_command_parse_and_encapsulate_mcc;

    localparam int CH = 4;

    logic              i_clk;
    logic              i_rst;
    logic              i_wr_cc;
    logic [31:0]       iv_wdata_cc;
    logic [18:0]       iv_addr_cc;
    logic              i_addr_fixed_cc;
    logic              i_rd_cc;
    logic              o_wr_cc;
    logic [31:0]       ov_rdata_cc;
    logic [18:0]       ov_raddr_cc;
    logic              o_addr_fixed_cc;
    logic [CH*32-1:0]  ov_cycle_length;
    logic [CH*64-1:0]  ov_oper_base;
    logic [CH-1:0]     ov_cfg_update;
    logic              o_addr_err;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] data;
        logic [18:0] addr;
        int          cyc;
    } rsp_t;
    rsp_t sb[$];

    logic [31:0] m_len  [CH];
    logic [63:0] m_base [CH];
    logic [31:0] m_sh   [CH];
    logic        m_pend [CH];
    logic        m_zerr [CH];

    command_parse_and_encapsulate_mcc #(.CH_NUM(CH)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_wr_cc         (i_wr_cc),
        .iv_wdata_cc     (iv_wdata_cc),
        .iv_addr_cc      (iv_addr_cc),
        .i_addr_fixed_cc (i_addr_fixed_cc),
        .i_rd_cc         (i_rd_cc),
        .o_wr_cc         (o_wr_cc),
        .ov_rdata_cc     (ov_rdata_cc),
        .ov_raddr_cc     (ov_raddr_cc),
        .o_addr_fixed_cc (o_addr_fixed_cc),
        .ov_cycle_length (ov_cycle_length),
        .ov_oper_base    (ov_oper_base),
        .ov_cfg_update   (ov_cfg_update),
        .o_addr_err      (o_addr_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Cycle counter used to time-stamp expected responses
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_len[c]  = 32'd100000;
            m_base[c] = 64'd60000000000;
            m_sh[c]   = 32'd0;
            m_pend[c] = 1'b0;
            m_zerr[c] = 1'b0;
        end
    endtask

    function automatic logic [31:0] model_read(input int c, input logic [1:0] off);
        case (off)
            2'd0:    return m_base[c][63:32];
            2'd1:    return m_base[c][31:0];
            2'd2:    return m_len[c];
            default: return {30'd0, m_zerr[c], m_pend[c]};
        endcase
    endfunction

    task automatic check_state(input string tag);
        logic [CH*32-1:0] exp_len;
        logic [CH*64-1:0] exp_base;
        for (int c = 0; c < CH; c++) begin
            exp_len[c*32 +: 32]  = m_len[c];
            exp_base[c*64 +: 64] = m_base[c];
        end
        check({tag, "_cycle_length"}, 256'(ov_cycle_length), 256'(exp_len));
        check({tag, "_oper_base"}, 256'(ov_oper_base), 256'(exp_base));
    endtask

    // Drive one command for one cycle, update the model, then check the pulses
    task automatic issue(input logic wr, input logic rd, input logic fixed,
                         input logic [18:0] addr, input logic [31:0] data);
        int          c;
        logic [1:0]  off;
        logic        mapped;
        logic [CH-1:0] exp_cfg;
        logic        exp_err;
        rsp_t        r;
        c       = int'(addr[18:2]);
        off     = addr[1:0];
        mapped  = !fixed && (c < CH);
        exp_cfg = '0;
        exp_err = !fixed && !mapped && (wr || rd);
        i_wr_cc         = wr;
        i_rd_cc         = rd;
        i_addr_fixed_cc = fixed;
        iv_addr_cc      = addr;
        iv_wdata_cc     = data;
        if (wr && mapped) begin
            case (off)
                2'd0: begin m_sh[c] = data; m_pend[c] = 1'b1; end
                2'd1: begin
                    m_base[c]  = {m_pend[c] ? m_sh[c] : m_base[c][63:32], data};
                    m_pend[c]  = 1'b0;
                    exp_cfg[c] = 1'b1;
                end
                2'd2: begin
                    if (data != 0) begin m_len[c] = data; exp_cfg[c] = 1'b1; end
                    else m_zerr[c] = 1'b1;
                end
                default: if (data[1]) m_zerr[c] = 1'b0;
            endcase
        end else if (rd && !wr && mapped) begin
            r.data = model_read(c, off);
            r.addr = addr;
            r.cyc  = cyc + 1;
            sb.push_back(r);
        end
        @(posedge i_clk);
        #1;
        i_wr_cc         = 1'b0;
        i_rd_cc         = 1'b0;
        i_addr_fixed_cc = 1'b0;
        iv_addr_cc      = '0;
        iv_wdata_cc     = '0;
        check("cfg_update", 256'(ov_cfg_update), 256'(exp_cfg));
        check("addr_err", 256'(o_addr_err), 256'(exp_err));
        check_state("state");
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        model_reset();
        @(posedge i_clk);
        #1;
        check("rst_rsp_valid", 256'(o_wr_cc), 256'(0));
        check("rst_cfg_update", 256'(ov_cfg_update), 256'(0));
        check("rst_addr_err", 256'(o_addr_err), 256'(0));
        check_state("rst");
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    // Response monitor: pop the scoreboard on every valid, else outputs must be zero
    always @(negedge i_clk) begin
        if (o_wr_cc === 1'b1) begin
            check("rsp_expected", 256'(sb.size() > 0), 256'(1));
            if (sb.size() > 0) begin
                rsp_t r;
                r = sb.pop_front();
                check("rsp_data", 256'(ov_rdata_cc), 256'(r.data));
                check("rsp_addr", 256'(ov_raddr_cc), 256'(r.addr));
                check("rsp_fixed", 256'(o_addr_fixed_cc), 256'(0));
                check("rsp_cycle", 256'(cyc), 256'(r.cyc));
            end
        end else begin
            check("idle_zero", 256'({o_wr_cc, o_addr_fixed_cc, ov_raddr_cc, ov_rdata_cc}), 256'(0));
        end
    end

    initial begin
        i_rst           = 1'b1;
        i_wr_cc         = 1'b0;
        i_rd_cc         = 1'b0;
        i_addr_fixed_cc = 1'b0;
        iv_addr_cc      = '0;
        iv_wdata_cc     = '0;
        model_reset();
        @(posedge i_clk);
        #1;
        do_reset();

        // default read-back of cycle length and low base word
        issue(1'b0, 1'b1, 1'b0, 19'd2, 32'd0);
        issue(1'b0, 1'b1, 1'b0, 19'd1, 32'd0);

        // shadowed 64-bit commit on channel 1
        issue(1'b1, 1'b0, 1'b0, 19'd4, 32'h1);
        issue(1'b0, 1'b1, 1'b0, 19'd4, 32'd0);
        issue(1'b1, 1'b0, 1'b0, 19'd5, 32'h2);
        check("ch1_commit", 256'(ov_oper_base[127:64]), 256'(64'h1_0000_0002));

        // zero cycle length is rejected and flagged, then cleared
        issue(1'b1, 1'b0, 1'b0, 19'd10, 32'd0);
        issue(1'b0, 1'b1, 1'b0, 19'd10, 32'd0);
        issue(1'b0, 1'b1, 1'b0, 19'd11, 32'd0);
        issue(1'b1, 1'b0, 1'b0, 19'd11, 32'h1);
        issue(1'b0, 1'b1, 1'b0, 19'd11, 32'd0);
        issue(1'b1, 1'b0, 1'b0, 19'd11, 32'h2);
        issue(1'b0, 1'b1, 1'b0, 19'd11, 32'd0);

        // simultaneous write and read: write only
        issue(1'b1, 1'b1, 1'b0, 19'd2, 32'd500);

        // unmapped and fixed-space accesses
        issue(1'b0, 1'b1, 1'b0, 19'd16, 32'd0);
        issue(1'b0, 1'b1, 1'b1, 19'd2, 32'd0);
        issue(1'b1, 1'b0, 1'b0, 19'h7FFFF, 32'd7);
        issue(1'b1, 1'b0, 1'b1, 19'd2, 32'd9);

        // back-to-back reads of channel 0
        issue(1'b0, 1'b1, 1'b0, 19'd0, 32'd0);
        issue(1'b0, 1'b1, 1'b0, 19'd1, 32'd0);
        issue(1'b0, 1'b1, 1'b0, 19'd2, 32'd0);
        issue(1'b0, 1'b1, 1'b0, 19'd3, 32'd0);

        // pending shadow visible in status, active hi unchanged until commit
        issue(1'b1, 1'b0, 1'b0, 19'd8, 32'hAB);
        issue(1'b0, 1'b1, 1'b0, 19'd11, 32'd0);
        issue(1'b0, 1'b1, 1'b0, 19'd8, 32'd0);
        issue(1'b1, 1'b0, 1'b0, 19'd9, 32'h1234);
        issue(1'b0, 1'b1, 1'b0, 19'd8, 32'd0);
        issue(1'b0, 1'b1, 1'b0, 19'd11, 32'd0);

        // low word commit without a pending shadow keeps the old hi
        issue(1'b1, 1'b0, 1'b0, 19'd13, 32'hCAFE);
        issue(1'b1, 1'b0, 1'b0, 19'd14, 32'hFFFF_FFFF);
        issue(1'b0, 1'b1, 1'b0, 19'd14, 32'd0);

        // reset between the hi and lo writes drops the shadow
        issue(1'b1, 1'b0, 1'b0, 19'd0, 32'h55);
        do_reset();
        issue(1'b1, 1'b0, 1'b0, 19'd1, 32'h7);
        check("rst_shadow_dropped", 256'(ov_oper_base[63:0]), 256'(64'hD_0000_0007));
        issue(1'b0, 1'b1, 1'b0, 19'd3, 32'd0);

        repeat (4) @(posedge i_clk);
        #1;
        check("sb_drained", 256'(sb.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/command_parse_and_encapsulate_mcc.md
COMMAND_PARSE_AND_ENCAPSULATE_MCC -- requirements
Module: command_parse_and_encapsulate_mcc

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, meaning number of cycle-control channels (1..64).
REQ-002 SHALL have parameter DEF_CYCLE_LEN, default 32'd100000, meaning reset cycle length per channel.
REQ-003 SHALL have parameter DEF_OPER_BASE, default 64'd60000000000, meaning reset operation base time per channel.
REQ-004 i_clk  in  1  sole clock; all logic on rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_wr_cc  in  1  write strobe, one cycle per command.
REQ-007 iv_wdata_cc  in  32  write data.
REQ-008 iv_addr_cc  in  19  register address.
REQ-009 i_addr_fixed_cc  in  1  fixed-address space flag; block decodes only when 0.
REQ-010 i_rd_cc  in  1  read strobe, one cycle per command.
REQ-011 o_wr_cc  out  1  read-response valid.
REQ-012 ov_rdata_cc  out  32  read-response data.
REQ-013 ov_raddr_cc  out  19  read-response address (echo).
REQ-014 o_addr_fixed_cc  out  1  read-response fixed flag (echo).
REQ-015 ov_cycle_length  out  CH_NUM*32  active cycle lengths; channel c at [c*32+31:c*32].
REQ-016 ov_oper_base  out  CH_NUM*64  active operation bases; channel c at [c*64+63:c*64].
REQ-017 ov_cfg_update  out  CH_NUM  per-channel one-cycle pulse on any active-value change.
REQ-018 o_addr_err  out  1  one-cycle pulse on unmapped access.

Function
REQ-019 Decode SHALL be: channel c = iv_addr_cc[18:2], offset = iv_addr_cc[1:0]; mapped only if i_addr_fixed_cc=0 and c < CH_NUM.
REQ-020 Offsets SHALL be: 0 oper_base[63:32], 1 oper_base[31:0], 2 cycle_length, 3 status.
REQ-021 Write offset 0 SHALL load a per-channel shadow-high register and set shadow_pending; active oper_base unchanged.
REQ-022 Write offset 1 SHALL commit {shadow_hi if pending else active hi, wdata} to active oper_base in one update, clear shadow_pending, pulse ov_cfg_update[c] next cycle.
REQ-023 Write offset 2 with nonzero data SHALL update cycle_length and pulse ov_cfg_update[c]; zero data SHALL be discarded and set sticky zlen_err[c].
REQ-024 Status read SHALL return {30'b0, zlen_err[c], shadow_pending[c]}; write offset 3 with wdata[1]=1 SHALL clear zlen_err[c] (W1C), other bits ignored.
REQ-025 Read of mapped address SHALL produce o_wr_cc=1 for exactly one cycle, the cycle after i_rd_cc, with data, address echo and fixed flag; offset 0 returns active hi, not shadow.
REQ-026 o_wr_cc, ov_rdata_cc, ov_raddr_cc, o_addr_fixed_cc SHALL be 0 in every cycle without a response.
REQ-027 i_wr_cc and i_rd_cc together SHALL execute the write only; the read is dropped, no response.
REQ-028 Unmapped write or read with i_addr_fixed_cc=0 SHALL pulse o_addr_err next cycle, no state change, no response; i_addr_fixed_cc=1 SHALL be ignored silently.
REQ-029 Back-to-back commands every cycle SHALL be accepted with no stall; each read gives one response.
REQ-030 ov_cfg_update pulses SHALL be registered, one cycle wide, only for the addressed channel.

Reset
REQ-031 During i_rst: all cycle_length = DEF_CYCLE_LEN, all oper_base = DEF_OPER_BASE, shadow registers 0, shadow_pending 0, zlen_err 0.
REQ-032 During i_rst: o_wr_cc, ov_rdata_cc, ov_raddr_cc, o_addr_fixed_cc, ov_cfg_update, o_addr_err all 0.
REQ-033 Reset asserted mid-sequence (after offset-0 write, before offset-1) SHALL discard the shadow; next offset-1 write combines with default hi.

Verification
REQ-034 Reset release, read addr 2 then addr 1 -> responses 100000 and 0xF8475800 (low word of 60e9), one cycle after each strobe.
REQ-035 Ch1: write addr 4 = 0x1, read addr 4, write addr 5 = 0x2 -> read returns old hi 0xD, ov_oper_base ch1 = 0x1_00000002 only after addr-5 write, single ov_cfg_update[1] pulse.
REQ-036 Write addr 10 = 0 -> ch2 cycle_length stays 100000, read addr 11 = 0x2; write addr 11 = 0x2, read addr 11 = 0x0.
REQ-037 Same-cycle write addr 2 = 500 and read addr 2 -> no response, cycle_length ch0 = 500, ov_cfg_update[0] pulses.
REQ-038 CH_NUM=4, read addr 16 -> o_addr_err pulse, o_wr_cc stays 0; read addr 2 with i_addr_fixed_cc=1 -> nothing.
REQ-039 Reads every cycle to addrs 0,1,2,3 -> four consecutive responses, echoed addresses in order.
